// File: rtl/instruction_queue.sv
// instruction_queue
//   Circular in-order instruction buffer between the fetch unit and the
//   reservation station. Entries are {pc, ins} pairs; issue pops the head
//   into a registered strobe/word/pc triple.
//
// Parameters
//   DEPTH_LOG        queue depth is 2**DEPTH_LOG entries
//
// Ports
//   clk_in           system clock, rising edge
//   rst_in           synchronous active-high reset (works even when rdy_in is low)
//   rdy_in           global ready; low freezes all state and outputs
//   flush_pipline    discard all queued entries and any same-cycle push
//   fetch_valid      fetch unit offers fetch_ins/fetch_pc this cycle
//   fetch_ins        offered instruction word
//   fetch_pc         PC of the offered instruction
//   fetch_ready      combinational: queue not full
//   rs_full          reservation station cannot take an issue this cycle
//   ins_just_issued  registered one-cycle issue strobe
//   ins_issued       registered instruction word accompanying the strobe
//   pc_issued        registered PC accompanying the strobe
//   queue_count      current occupancy
//
// Configuration macro
//   IQ_BYPASS_EN     when defined, a push into an empty queue that could issue
//                    immediately goes straight to the issue registers
//                    (1-edge latency) without touching storage.

module instruction_queue #(
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_pipline,
  input  logic                 fetch_valid,
  input  logic [31:0]          fetch_ins,
  input  logic [31:0]          fetch_pc,
  output logic                 fetch_ready,
  input  logic                 rs_full,
  output logic                 ins_just_issued,
  output logic [31:0]          ins_issued,
  output logic [31:0]          pc_issued,
  output logic [DEPTH_LOG:0]   queue_count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_COUNT = {1'b1, {DEPTH_LOG{1'b0}}};

  logic [63:0]          entries [DEPTH];
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic [DEPTH_LOG:0]   count;

  logic empty;
  logic push_ok;
  logic issue_ok;
  logic bypass;
  logic write_en;

  assign empty       = (count == '0);
  // Full refuses a push even if a pop happens in the same cycle; this keeps
  // fetch_ready free of any dependency on rs_full.
  assign fetch_ready = (count != FULL_COUNT);
  assign queue_count = count;

  assign push_ok  = rdy_in & fetch_valid & fetch_ready & ~flush_pipline;
  assign issue_ok = rdy_in & ~flush_pipline & ~rs_full & ~empty;

`ifdef IQ_BYPASS_EN
  assign bypass = push_ok & empty & ~rs_full;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction never lands in storage.
  assign write_en = push_ok & ~bypass;

  always_ff @(posedge clk_in) begin
    if (!rst_in && write_en) begin
      entries[tail] <= {fetch_pc, fetch_ins};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      ins_just_issued <= 1'b0;
      ins_issued      <= '0;
      pc_issued       <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        head            <= '0;
        tail            <= '0;
        count           <= '0;
        ins_just_issued <= 1'b0;
      end else begin
        if (write_en) begin
          tail <= tail + DEPTH_LOG'(1);
        end
        if (issue_ok) begin
          head <= head + DEPTH_LOG'(1);
        end

        case ({write_en, issue_ok})
          2'b10:   count <= count + (DEPTH_LOG + 1)'(1);
          2'b01:   count <= count - (DEPTH_LOG + 1)'(1);
          default: count <= count;
        endcase

        // ins_issued/pc_issued hold their last value when nothing issues.
        ins_just_issued <= issue_ok | bypass;
        if (bypass) begin
          ins_issued <= fetch_ins;
          pc_issued  <= fetch_pc;
        end else if (issue_ok) begin
          ins_issued <= entries[head][31:0];
          pc_issued  <= entries[head][63:32];
        end
      end
    end
  end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 3, queue depth = 2**DEPTH_LOG entries.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_in input 1, system clock, all state updates on rising edge.
REQ-003 SHALL have rst_in input 1, synchronous active-high reset.
REQ-004 SHALL have rdy_in input 1, global ready; low pauses the block.
REQ-005 SHALL have flush_pipline input 1, discard all queued and in-flight instructions.
REQ-006 SHALL have fetch_valid input 1, fetch unit offers an instruction this cycle.
REQ-007 SHALL have fetch_ins input 32, offered instruction word.
REQ-008 SHALL have fetch_pc input 32, PC of offered instruction.
REQ-009 SHALL have fetch_ready output 1, combinational: queue not full.
REQ-010 SHALL have rs_full input 1, reservation station cannot accept an issue this cycle.
REQ-011 SHALL have ins_just_issued output 1, registered issue strobe to reservation station.
REQ-012 SHALL have ins_issued output 32, registered instruction word accompanying the strobe.
REQ-013 SHALL have pc_issued output 32, registered PC accompanying the strobe.
REQ-014 SHALL have queue_count output DEPTH_LOG+1, current occupancy.

Function
REQ-015 SHALL store {pc, ins} pairs in a circular buffer with head/tail pointers of DEPTH_LOG bits wrapping modulo depth, count of DEPTH_LOG+1 bits.
REQ-016 SHALL accept a push at a rising edge iff rdy_in & fetch_valid & fetch_ready & !flush_pipline.
REQ-017 SHALL drive fetch_ready = (count != depth); a full queue refuses push even when a pop occurs in the same cycle.
REQ-018 SHALL issue (pop head) at a rising edge iff rdy_in & !flush_pipline & !rs_full & count != 0.
REQ-019 SHALL on issue register ins_issued/pc_issued from the head entry and set ins_just_issued = 1; otherwise ins_just_issued = 0 and ins_issued/pc_issued hold.
REQ-020 SHALL keep ins_just_issued high for exactly one active (rdy_in high) cycle per issued instruction; back-to-back issues keep it high on consecutive cycles.
REQ-021 SHALL support simultaneous push and issue in one cycle (count unchanged) when not full.
REQ-022 SHALL preserve strict program order: issue order equals push order.
REQ-023 SHALL on flush_pipline high (with rdy_in high) clear head, tail, count to 0, drop any same-cycle push, and drive ins_just_issued = 0 next cycle.
REQ-024 SHALL while rdy_in is low freeze all state and outputs, including a pending ins_just_issued, ignoring fetch_valid, rs_full and flush_pipline.
REQ-025 SHALL give push-to-strobe latency of 2 edges from an empty queue without bypass (written at edge N, ins_just_issued high after edge N+1).

Reset
REQ-026 SHALL on rst_in high at a rising edge, regardless of rdy_in, set head=tail=count=0, ins_just_issued=0, ins_issued=0, pc_issued=0.
REQ-027 SHALL give reset priority over flush, push and issue; reset mid-operation discards all entries.

Configuration
REQ-028 SHALL support macro IQ_BYPASS_EN: when defined and count==0 with a legal push and issue conditions otherwise met, the fetched instruction is driven directly onto ins_issued/pc_issued with ins_just_issued=1 at the same edge, not written to storage, count stays 0 (latency 1 edge).
REQ-029 SHALL without IQ_BYPASS_EN never bypass; an empty queue cannot issue in the cycle of a push.

Verification
REQ-030 SHALL cover: reset, then push 0x00000013@pc 0x0 with rs_full=0 -> ins_just_issued high one cycle after edge N+1 (N with IQ_BYPASS_EN), ins_issued=0x00000013, pc_issued=0x0.
REQ-031 SHALL cover: rs_full=1, push 9 instructions (DEPTH_LOG=3) -> fetch_ready low after 8th, 9th refused, queue_count=8; release rs_full -> 8 issues in order on 8 consecutive cycles.
REQ-032 SHALL cover: continuous push and issue for 20 cycles -> pointers wrap, queue_count constant, issued sequence equals pushed sequence.
REQ-033 SHALL cover: queue holding 5 entries, flush_pipline with fetch_valid=1 -> next cycle queue_count=0, ins_just_issued=0, pushed instruction lost.
REQ-034 SHALL cover: rdy_in low for 3 cycles while ins_just_issued=1 and fetch_valid=1 -> all outputs and queue_count held; strobe consumed once after rdy_in returns.
REQ-035 SHALL cover: rst_in high while queue_count=4 and rdy_in=0 -> next cycle all outputs 0, queue_count=0.
